apb_master: RTL and testbench

- APB requester that drives the peripheral-side APB slave stage (psel/pen/pwrite/paddr/pwdata out; prdata/pready/pslverr in).
- Upstream it accepts single read/write commands over a valid/ready handshake and returns one response per command.
- Implements the APB SETUP→ACCESS protocol, wait-state handling and a bounded-wait timeout so a stuck slave cannot hang the requester.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_wait_timer.sv | 30 +++
 rtl/apb_master.sv | 99 +++++++++
 tb/tb_apb_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// default wait-state timeout used by the requester, slave and bench.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_master_if.sv
// Upstream command/response handshake plus the APB requester-side bus.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              pen;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, pen, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, pen, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; o_expired flags the last
// permitted wait cycle. 8-bit saturating, so TIMEOUT must stay within 2..255.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != 8'hFF))
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time, runs SETUP->ACCESS with wait
// states, and returns a single response pulse (timeout aborts a stuck slave).
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input logic          pclk,
    input logic          prst,
    apb_master_if.master bus
);

    apb_state_t        r_state;
    logic              r_psel;
    logic              r_pen;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_clr;
    logic              w_en;
    logic              w_expired;

    assign w_clr = (r_state == SETUP);
    assign w_en  = (r_state == ACCESS) && !bus.pready;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (pclk),
        .i_rst_n   (prst),
        .i_clr     (w_clr),
        .i_en      (w_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_pen       <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite <= bus.cmd_write;
                        r_paddr  <= bus.cmd_addr;
                        r_pwdata <= bus.cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_pen   <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    // pready takes priority over a timeout expiring on the same edge
                    if (bus.pready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_err   <= bus.pslverr;
                        r_psel      <= 1'b0;
                        r_pen       <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_pen       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.psel      = r_psel;
    assign bus.pen       = r_pen;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: programmable-wait APB slave, a transaction-timeline
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = APB_TIMEOUT_DEF;

    logic pclk = 1'b0;
    logic prst = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_if #(.ADDR_W(APB_ADDR_W), .DATA_W(APB_DATA_W)) bus ();

    apb_master #(.ADDR_W(APB_ADDR_W), .DATA_W(APB_DATA_W), .TIMEOUT(TO)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: pready rises on ACCESS cycle index cfg_wait (0 = zero-wait).
    // junk drives pready/pslverr high whenever the bus is not in ACCESS.
    int          cfg_wait = 0;
    bit          cfg_err  = 1'b0;
    bit          junk     = 1'b0;
    int          acc      = 0;
    logic [31:0] smem [int];

    always @(posedge pclk) begin
        #1;
        if (prst && bus.psel && bus.pen) begin
            if (acc == cfg_wait) begin
                bus.pready  = 1'b1;
                bus.pslverr = cfg_err;
                bus.prdata  = smem.exists(int'(bus.paddr)) ? smem[int'(bus.paddr)] : 32'h0;
                if (bus.pwrite) smem[int'(bus.paddr)] = bus.pwdata;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                bus.prdata  = 32'h0;
            end
            acc++;
        end else begin
            acc         = 0;
            bus.pready  = junk;
            bus.pslverr = junk;
            bus.prdata  = junk ? 32'h0BAD_C0DE : 32'h0;
        end
    end

    // Reference model: after an accept, cycle t=1 is SETUP, t=2..A+1 are ACCESS,
    // t=A+2 carries the response. A = wait+1, or TO when the slave never answers in time.
    bit          m_busy = 1'b0;
    int          m_t    = 0;
    int          m_a    = 0;
    bit          m_wr, m_to, m_se;
    logic [31:0] m_ad, m_wd;
    logic [31:0] e_rd   = 32'h0;
    logic        e_er   = 1'b0;
    logic [31:0] mmem [int];

    always @(negedge pclk) begin
        logic ep, ee, erv, erdy;
        if (!prst) begin
            m_busy = 1'b0;
            e_rd   = 32'h0;
            e_er   = 1'b0;
            chk("rst_psel",  bus.psel, 0);
            chk("rst_pen",   bus.pen, 0);
            chk("rst_pwrite", bus.pwrite, 0);
            chk("rst_paddr", bus.paddr, 0);
            chk("rst_pwdata", bus.pwdata, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_cmd_ready", bus.cmd_ready, 1);
        end else begin
            ep   = m_busy && (m_t >= 1) && (m_t <= m_a + 1);
            ee   = m_busy && (m_t >= 2) && (m_t <= m_a + 1);
            erv  = m_busy && (m_t == m_a + 2);
            erdy = !ep;
            if (erv) begin
                e_er = m_to ? 1'b1 : m_se;
                e_rd = (m_to || m_wr) ? 32'h0 : (mmem.exists(int'(m_ad)) ? mmem[int'(m_ad)] : 32'h0);
                if (m_wr && !m_to) mmem[int'(m_ad)] = m_wd;
            end
            chk("psel", bus.psel, ep);
            chk("pen", bus.pen, ee);
            chk("cmd_ready", bus.cmd_ready, erdy);
            chk("rsp_valid", bus.rsp_valid, erv);
            chk("rsp_rdata", bus.rsp_rdata, e_rd);
            chk("rsp_err", bus.rsp_err, e_er);
            if (ep) begin
                chk("paddr", bus.paddr, m_ad);
                chk("pwrite", bus.pwrite, m_wr);
                chk("pwdata", bus.pwdata, m_wd);
            end
            if (m_busy) begin
                m_t++;
                if (m_t > m_a + 2) m_busy = 1'b0;
            end
            if (erdy && bus.cmd_valid) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_wr   = bus.cmd_write;
                m_ad   = bus.cmd_addr;
                m_wd   = bus.cmd_wdata;
                m_se   = cfg_err;
                m_to   = (cfg_wait >= TO);
                m_a    = m_to ? TO : cfg_wait + 1;
            end
        end
    end

    // One command; off = clock edges from the accept edge to the completing edge.
    task automatic issue(input bit wr, input logic [31:0] ad, input logic [31:0] wd,
                         input int wt, input bit se,
                         output int off, output logic [31:0] rd, output logic er);
        int n;
        @(posedge pclk);
        #1;
        cfg_wait      = wt;
        cfg_err       = se;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = ad;
        bus.cmd_wdata = wd;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!bus.cmd_ready && n < 300);
        chk("accept_ready", bus.cmd_ready, 1);
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!bus.rsp_valid && n < 300);
        chk("rsp_seen", bus.rsp_valid, 1);
        off = n - 1;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
    endtask

    initial begin
        int          off;
        int          n;
        logic [31:0] rd;
        logic        er;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = 32'h0;
        #1 prst = 1'b0;
        repeat (3) @(posedge pclk);
        #2 prst = 1'b1;
        @(negedge pclk);
        chk("idle_ready", bus.cmd_ready, 1);

        // registered-pready slave: two ACCESS cycles
        issue(1'b1, 32'h3, 32'hDEAD_BEEF, 1, 1'b0, off, rd, er);
        chk("wr_lat", off, 3);
        chk("wr_err", er, 0);
        chk("wr_rdata", rd, 0);

        issue(1'b0, 32'h3, 32'h1111_2222, 1, 1'b0, off, rd, er);
        chk("rd_lat", off, 3);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);

        // five wait cycles then pready with pslverr
        issue(1'b0, 32'h3, 32'h0, 5, 1'b1, off, rd, er);
        chk("wait5_lat", off, 7);
        chk("wait5_err", er, 1);

        // slave never answers: abort after TO ACCESS cycles
        issue(1'b1, 32'h8, 32'hCAFE_F00D, 255, 1'b0, off, rd, er);
        chk("to_lat", off, 17);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);
        chk("to_psel_after", bus.psel, 0);

        issue(1'b0, 32'h8, 32'h0, 0, 1'b0, off, rd, er);
        chk("after_to_lat", off, 2);
        chk("after_to_rdata", rd, 0);
        chk("after_to_err", er, 0);

        // pready arrives on the very cycle the timeout would fire
        issue(1'b0, 32'h3, 32'h0, TO - 1, 1'b0, off, rd, er);
        chk("edge_lat", off, 17);
        chk("edge_err", er, 0);
        chk("edge_rdata", rd, 32'hDEAD_BEEF);

        // stray pready/pslverr outside ACCESS must be ignored
        junk = 1'b1;
        issue(1'b1, 32'h5, 32'h1234_5678, 0, 1'b0, off, rd, er);
        chk("junk_wr_lat", off, 2);
        chk("junk_wr_err", er, 0);
        issue(1'b0, 32'h5, 32'h0, 2, 1'b0, off, rd, er);
        chk("junk_rd_lat", off, 4);
        chk("junk_rd_rdata", rd, 32'h1234_5678);
        junk = 1'b0;

        // back-to-back reads with reset asserted mid-ACCESS of the second one
        @(posedge pclk);
        #1;
        cfg_wait      = 3;
        cfg_err       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h3;
        bus.cmd_wdata = 32'h0;
        repeat (8) @(posedge pclk);
        #2;
        chk("b2b_psel_pre", bus.psel, 1);
        chk("b2b_pen_pre", bus.pen, 1);
        chk("b2b_rdata_pre", bus.rsp_rdata, 32'hDEAD_BEEF);
        #1 prst = 1'b0;
        #1;
        chk("async_psel", bus.psel, 0);
        chk("async_pen", bus.pen, 0);
        chk("async_paddr", bus.paddr, 0);
        chk("async_rsp_valid", bus.rsp_valid, 0);
        chk("async_rsp_rdata", bus.rsp_rdata, 0);
        chk("async_rsp_err", bus.rsp_err, 0);
        repeat (2) @(posedge pclk);
        #2 prst = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!bus.rsp_valid && n < 300);
        chk("post_rst_rsp", bus.rsp_valid, 1);
        chk("post_rst_lat", n, 7);
        chk("post_rst_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        @(posedge pclk);
        #1 bus.cmd_valid = 1'b0;
        repeat (30) @(posedge pclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
